alarm_ring_cont: RTL and testbench

- Consumes the 17-bit alarm time produced by the alarm time-set control and the running clock time.
- Detects the alarm match and drives ring/buzzer outputs with stop, snooze and auto-timeout handling.
- Sits between the alarm time-set block, the timekeeping counter and the buzzer/LED outputs.
- Time word format on both inputs: bit16 MERIDIAN (0=AM, 1=PM), [15:12] HOUR 0..11, [11:6] MIN 0..59, [5:0] SEC 0..59.

---
 rtl/alarm_ring_cont_if.sv | 26 ++
 rtl/alarm_ring_cont.sv | 160 ++++++++++++++++
 tb/tb_alarm_ring_cont.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alarm_ring_cont_if.sv
// Alarm ring control bus: time inputs, UI pulses and ring/buzzer outputs.
// master = the driver of the alarm inputs, slave = alarm_ring_cont.
interface alarm_ring_cont_if;
    logic        SEC_TICK;
    logic [16:0] CUR_TIME;
    logic [16:0] ALARM_TIME;
    logic        ALARM_EN;
    logic [2:0]  FLAG;
    logic        STOP;
    logic        SNOOZE;
    logic        RING;
    logic        BUZZ;
    logic        SNOOZE_ACT;
    logic [1:0]  SNOOZE_CNT;
    logic [1:0]  STATE;

    modport master (
        output SEC_TICK, CUR_TIME, ALARM_TIME, ALARM_EN, FLAG, STOP, SNOOZE,
        input  RING, BUZZ, SNOOZE_ACT, SNOOZE_CNT, STATE
    );

    modport slave (
        input  SEC_TICK, CUR_TIME, ALARM_TIME, ALARM_EN, FLAG, STOP, SNOOZE,
        output RING, BUZZ, SNOOZE_ACT, SNOOZE_CNT, STATE
    );
endinterface

// File: rtl/alarm_ring_cont.sv
// Alarm ring controller: detects the alarm match edge and runs the
// IDLE/ARMED/RINGING/SNOOZE sequence with stop, snooze and ring timeout.
// Optional macro ALARM_AUTO_SNOOZE_EN: a ring timeout behaves like a
// SNOOZE press instead of returning straight to ARMED.
module alarm_ring_cont #(
    parameter int         RING_SEC                 = 60,
    parameter int         SNOOZE_SEC               = 300,
    parameter int         MAX_SNOOZE               = 3,
    parameter logic [2:0] FLAG_ALARM_CONTROL_STATE = 3'b101
) (
    input  logic              CLK,
    input  logic              RESET,
    alarm_ring_cont_if.slave  bus
);

    localparam int RW = $clog2(RING_SEC + 1);
    localparam int SW = $clog2(SNOOZE_SEC + 1);
    localparam logic [RW-1:0] RING_LD   = RW'(RING_SEC);
    localparam logic [SW-1:0] SNOOZE_LD = SW'(SNOOZE_SEC);
    localparam logic [1:0]    MAX_SN    = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RINGING = 2'd2,
        S_SNOOZE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  ring_cnt_q, ring_cnt_d;
    logic [SW-1:0]  snz_cnt_q, snz_cnt_d;
    logic [1:0]     snz_used_q, snz_used_d;
    logic           buzz_q, buzz_d;
    logic           ring_q, ring_d;
    logic           sact_q, sact_d;
    logic           match_q;

    logic           match;
    logic           match_rise;
    logic           snooze_req;

    // Only a fresh match edge can start a ring; a held match never retriggers.
    assign match      = (bus.CUR_TIME == bus.ALARM_TIME);
    assign match_rise = match && !match_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        snz_used_d = snz_used_q;
        buzz_d     = buzz_q;
        snooze_req = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.ALARM_EN) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!bus.ALARM_EN) begin
                    state_d = S_IDLE;
                end else if (match_rise && (bus.FLAG != FLAG_ALARM_CONTROL_STATE)) begin
                    state_d    = S_RINGING;
                    ring_cnt_d = RING_LD;
                    buzz_d     = 1'b1;
                    snz_used_d = 2'd0;
                end
            end
            S_RINGING: begin
                // Disarm beats STOP, STOP beats SNOOZE, and any press eats a
                // coincident SEC_TICK.
                if (!bus.ALARM_EN) begin
                    state_d = S_IDLE;
                end else if (bus.STOP) begin
                    state_d = S_ARMED;
                end else if (bus.SNOOZE) begin
                    snooze_req = 1'b1;
                end else if (bus.SEC_TICK) begin
                    if (ring_cnt_q <= RW'(1)) begin
                        ring_cnt_d = '0;
`ifdef ALARM_AUTO_SNOOZE_EN
                        snooze_req = 1'b1;
`else
                        state_d    = S_ARMED;
`endif
                    end else begin
                        ring_cnt_d = ring_cnt_q - RW'(1);
                        buzz_d     = !buzz_q;
                    end
                end
                // Snooze budget exhausted: the press dismisses the event.
                if (snooze_req) begin
                    if (snz_used_q < MAX_SN) begin
                        state_d    = S_SNOOZE;
                        snz_cnt_d  = SNOOZE_LD;
                        snz_used_d = snz_used_q + 2'd1;
                    end else begin
                        state_d    = S_ARMED;
                        snz_used_d = 2'd0;
                    end
                end
            end
            S_SNOOZE: begin
                // Extra SNOOZE presses are ignored here.
                if (!bus.ALARM_EN) begin
                    state_d = S_IDLE;
                end else if (bus.STOP) begin
                    state_d    = S_ARMED;
                    snz_used_d = 2'd0;
                end else if (bus.SEC_TICK) begin
                    if (snz_cnt_q <= SW'(1)) begin
                        snz_cnt_d  = '0;
                        state_d    = S_RINGING;
                        ring_cnt_d = RING_LD;
                        buzz_d     = 1'b1;
                    end else begin
                        snz_cnt_d = snz_cnt_q - SW'(1);
                    end
                end
            end
        endcase

        // Buzzer is only ever driven while ringing; disarming ends the event.
        if (state_d != S_RINGING) buzz_d = 1'b0;
        if (state_d == S_IDLE)    snz_used_d = 2'd0;

        ring_d = (state_d == S_RINGING);
        sact_d = (state_d == S_SNOOZE);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            snz_used_q <= 2'd0;
            buzz_q     <= 1'b0;
            ring_q     <= 1'b0;
            sact_q     <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            snz_used_q <= snz_used_d;
            buzz_q     <= buzz_d;
            ring_q     <= ring_d;
            sact_q     <= sact_d;
            match_q    <= match;
        end
    end

    assign bus.STATE      = state_q;
    assign bus.RING       = ring_q;
    assign bus.BUZZ       = buzz_q;
    assign bus.SNOOZE_ACT = sact_q;
    assign bus.SNOOZE_CNT = snz_used_q;

endmodule

// File: tb/tb_alarm_ring_cont.sv
// Scoreboard bench for alarm_ring_cont: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_alarm_ring_cont;

    logic CLK = 1'b0;
    logic RESET;

    alarm_ring_cont_if bus ();

    alarm_ring_cont dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] st;
        logic       ring;
        logic       buzz;
        logic       sact;
        logic [1:0] scnt;
        logic       scnt_dc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    localparam logic [16:0] T_ALARM = {1'b0, 4'd7, 6'd30, 6'd0};
    localparam logic [16:0] T_PREV  = {1'b0, 4'd7, 6'd29, 6'd59};
    localparam logic [16:0] T_NEXT  = {1'b0, 4'd7, 6'd30, 6'd1};

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            logic  bad;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            bad = (bus.STATE != e.st) || (bus.RING != e.ring) || (bus.BUZZ != e.buzz) ||
                  (bus.SNOOZE_ACT != e.sact) || (!e.scnt_dc && (bus.SNOOZE_CNT != e.scnt));
            if (bad) begin
                n_err++;
                $display("FAIL %s: got STATE=%0d RING=%0b BUZZ=%0b SACT=%0b SCNT=%0d, want STATE=%0d RING=%0b BUZZ=%0b SACT=%0b SCNT=%0d%s",
                         nm, bus.STATE, bus.RING, bus.BUZZ, bus.SNOOZE_ACT, bus.SNOOZE_CNT,
                         e.st, e.ring, e.buzz, e.sact, e.scnt, e.scnt_dc ? "(any)" : "");
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            bus.SEC_TICK = 1'b1;
            step();
            bus.SEC_TICK = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input int st, input bit ring, input bit buzz,
                       input bit sact, input int scnt);
        exp_t e;
        e.st      = 2'(st);
        e.ring    = ring;
        e.buzz    = buzz;
        e.sact    = sact;
        e.scnt    = 2'(scnt);
        e.scnt_dc = (scnt < 0);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Force a new match edge while ARMED.
    task automatic retrigger();
        bus.CUR_TIME = T_NEXT;
        step();
        bus.CUR_TIME = T_ALARM;
        step();
    endtask

    task automatic pulse_snooze();
        bus.SNOOZE = 1'b1;
        step();
        bus.SNOOZE = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.STOP = 1'b1;
        step();
        bus.STOP = 1'b0;
    endtask

    initial begin
        RESET          = 1'b1;
        bus.SEC_TICK   = 1'b0;
        bus.CUR_TIME   = T_PREV;
        bus.ALARM_TIME = T_ALARM;
        bus.ALARM_EN   = 1'b0;
        bus.FLAG       = 3'b000;
        bus.STOP       = 1'b0;
        bus.SNOOZE     = 1'b0;
        step();
        RESET = 1'b0;
        chk("reset", 0, 0, 0, 0, 0);

        // Basic ring
        bus.ALARM_EN = 1'b1;
        step();                       chk("armed", 1, 0, 0, 0, 0);
        bus.CUR_TIME = T_ALARM;
        step();                       chk("ring_entry", 2, 1, 1, 0, 0);
        tick(1);                      chk("buzz_toggle0", 2, 1, 0, 0, 0);
        tick(1);                      chk("buzz_toggle1", 2, 1, 1, 0, 0);
        tick(57);                     chk("ring_59", 2, 1, 0, 0, 0);

        // Timeout on the 60th tick
        tick(1);
`ifdef ALARM_AUTO_SNOOZE_EN
        chk("timeout_auto", 3, 0, 0, 1, 1);
        pulse_stop();
`else
        chk("timeout", 1, 0, 0, 0, 0);
`endif
        chk("post_timeout", 1, 0, 0, 0, 0);

        // Snooze cycle up to the budget
        retrigger();                  chk("ring2", 2, 1, 1, 0, 0);
        pulse_snooze();               chk("snooze1", 3, 0, 0, 1, 1);
        pulse_snooze();               chk("snooze_ignored", 3, 0, 0, 1, 1);
        tick(299);                    chk("snooze_299", 3, 0, 0, 1, 1);
        tick(1);                      chk("snooze_end1", 2, 1, 1, 0, 1);
        bus.SEC_TICK = 1'b1;          // tick consumed by the snooze press
        pulse_snooze();
        bus.SEC_TICK = 1'b0;          chk("snooze2_tick", 3, 0, 0, 1, 2);
        tick(299);                    chk("snooze2_299", 3, 0, 0, 1, 2);
        tick(1);                      chk("snooze_end2", 2, 1, 1, 0, 2);
        pulse_snooze();               chk("snooze3", 3, 0, 0, 1, 3);
        tick(300);                    chk("snooze_end3", 2, 1, 1, 0, 3);
        pulse_snooze();               chk("fourth_snooze", 1, 0, 0, 0, 0);

        // STOP beats SNOOZE; count unchanged
        retrigger();                  chk("ring3", 2, 1, 1, 0, 0);
        pulse_snooze();               chk("snooze_p", 3, 0, 0, 1, 1);
        tick(300);                    chk("ring_p", 2, 1, 1, 0, 1);
        bus.STOP = 1'b1;
        pulse_snooze();
        bus.STOP = 1'b0;              chk("stop_wins", 1, 0, 0, 0, 1);

        // Disarm during SNOOZE
        retrigger();                  chk("ring4", 2, 1, 1, 0, 0);
        pulse_snooze();               chk("snooze_d", 3, 0, 0, 1, 1);
        bus.ALARM_EN = 1'b0;
        step();                       chk("disarm_snooze", 0, 0, 0, 0, -1);
        bus.ALARM_EN = 1'b1;
        step();                       chk("rearm", 1, 0, 0, 0, -1);

        // STOP during SNOOZE clears the count
        retrigger();                  chk("ring5", 2, 1, 1, 0, 0);
        pulse_snooze();               chk("snooze_s", 3, 0, 0, 1, 1);
        pulse_stop();                 chk("snooze_stop", 1, 0, 0, 0, 0);

        // Edit suppression
        bus.FLAG = 3'b101;
        retrigger();                  chk("edit_block", 1, 0, 0, 0, 0);
        bus.FLAG = 3'b000;
        step();                       chk("edit_hold1", 1, 0, 0, 0, 0);
        step();                       chk("edit_hold2", 1, 0, 0, 0, 0);
        step();                       chk("edit_hold3", 1, 0, 0, 0, 0);

        // Reset mid-ring
        retrigger();                  chk("ring6", 2, 1, 1, 0, 0);
        tick(3);                      chk("ring6_t3", 2, 1, 0, 0, 0);
        RESET = 1'b1;
        step();                       chk("reset_mid", 0, 0, 0, 0, 0);
        RESET = 1'b0;
        step();                       chk("post_reset1", 1, 0, 0, 0, 0);
        step();                       chk("post_reset2", 1, 0, 0, 0, 0);
        step();                       chk("post_reset3", 1, 0, 0, 0, 0);

        // Drain scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        @(posedge CLK);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
